// File: rtl/bit_deshift_if.sv
// rtl/bit_deshift_if.sv - beat-in / word-out stream bundle for bit_deshift (parity_err present with BIT_DESHIFT_PARITY_EN)
interface bit_deshift_if #(
  parameter int NB = 1,
  parameter int DW = 8
) ();
  logic [NB-1:0] din;
  logic          din_valid;
  logic          din_sof;
  logic          din_ready;
  logic [DW-1:0] data_out;
  logic          data_valid;
  logic          data_ready;
`ifdef BIT_DESHIFT_PARITY_EN
  logic          parity_err;

  modport master (
    output din, din_valid, din_sof, data_ready,
    input  din_ready, data_out, data_valid, parity_err
  );

  modport slave (
    input  din, din_valid, din_sof, data_ready,
    output din_ready, data_out, data_valid, parity_err
  );
`else
  modport master (
    output din, din_valid, din_sof, data_ready,
    input  din_ready, data_out, data_valid
  );

  modport slave (
    input  din, din_valid, din_sof, data_ready,
    output din_ready, data_out, data_valid
  );
`endif
endinterface

// File: rtl/bit_deshift.sv
// rtl/bit_deshift.sv - serial-to-parallel shift-in register; BIT_DESHIFT_PARITY_EN adds a trailing parity beat and parity_err
module bit_deshift #(
  parameter int DATA_WIDTH      = 8,
  parameter int SHIFT_DIRECTION = 1,
  parameter int NUMBER_BITS     = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  bit_deshift_if.slave bus
);

  localparam int BEATS = DATA_WIDTH / NUMBER_BITS;
  localparam int CW    = $clog2(BEATS) + 1;
`ifdef BIT_DESHIFT_PARITY_EN
  // the beat after the last data beat carries parity
  localparam logic [CW-1:0] LAST_BEAT = CW'(BEATS);
`else
  localparam logic [CW-1:0] LAST_BEAT = CW'(BEATS - 1);
`endif

  typedef enum logic {FILL, HOLD} state_t;

  state_t                state, state_n;
  logic [DATA_WIDTH-1:0] sreg, sreg_n;
  logic [DATA_WIDTH-1:0] data_q, data_n;
  logic                  valid_q, valid_n;
  logic [CW-1:0]         count, count_n;
  logic [DATA_WIDTH-1:0] base, shifted, done_word;
  logic [CW-1:0]         eff_count;
  logic                  accept, consume, slot_free, word_done;
`ifdef BIT_DESHIFT_PARITY_EN
  logic                  perr_q, perr_n;
  logic                  hold_perr, hold_perr_n;
  logic                  done_perr;
`endif

  assign accept    = bus.din_valid && (state == FILL);
  assign consume   = valid_q && bus.data_ready;
  assign slot_free = !valid_q || bus.data_ready;

  // a start-of-word beat throws away whatever partial word was collected
  assign base      = bus.din_sof ? '0 : sreg;
  assign eff_count = bus.din_sof ? '0 : count;

  generate
    if (BEATS == 1) begin : g_single
      assign shifted = bus.din;
    end else if (SHIFT_DIRECTION == 1) begin : g_right
      assign shifted = {bus.din, base[DATA_WIDTH-1:NUMBER_BITS]};
    end else begin : g_left
      assign shifted = {base[DATA_WIDTH-NUMBER_BITS-1:0], bus.din};
    end
  endgenerate

  assign word_done = (eff_count == LAST_BEAT);
`ifdef BIT_DESHIFT_PARITY_EN
  // on the parity beat the data is already complete in sreg
  assign done_word = sreg;
  assign done_perr = (^sreg) ^ bus.din[0];
`else
  assign done_word = shifted;
`endif

  // next-state and datapath update for the FILL/HOLD machine
  always_comb begin
    state_n = state;
    sreg_n  = sreg;
    count_n = count;
    data_n  = data_q;
    valid_n = valid_q;
`ifdef BIT_DESHIFT_PARITY_EN
    perr_n      = perr_q;
    hold_perr_n = hold_perr;
`endif
    if (consume) begin
      valid_n = 1'b0;
    end
    case (state)
      FILL: begin
        if (accept) begin
          if (word_done) begin
            count_n = '0;
            if (slot_free) begin
              data_n  = done_word;
              valid_n = 1'b1;
              sreg_n  = '0;
`ifdef BIT_DESHIFT_PARITY_EN
              perr_n  = done_perr;
`endif
            end else begin
              sreg_n  = done_word;
              state_n = HOLD;
`ifdef BIT_DESHIFT_PARITY_EN
              hold_perr_n = done_perr;
`endif
            end
          end else begin
            sreg_n  = shifted;
            count_n = eff_count + CW'(1);
          end
        end
      end
      HOLD: begin
        if (slot_free) begin
          data_n  = sreg;
          valid_n = 1'b1;
          sreg_n  = '0;
          count_n = '0;
          state_n = FILL;
`ifdef BIT_DESHIFT_PARITY_EN
          perr_n  = hold_perr;
`endif
        end
      end
      default: state_n = FILL;
    endcase
  end

  // state and datapath registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= FILL;
      sreg    <= '0;
      count   <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
`ifdef BIT_DESHIFT_PARITY_EN
      perr_q    <= 1'b0;
      hold_perr <= 1'b0;
`endif
    end else begin
      state   <= state_n;
      sreg    <= sreg_n;
      count   <= count_n;
      data_q  <= data_n;
      valid_q <= valid_n;
`ifdef BIT_DESHIFT_PARITY_EN
      perr_q    <= perr_n;
      hold_perr <= hold_perr_n;
`endif
    end
  end

  assign bus.din_ready  = (state == FILL);
  assign bus.data_out   = data_q;
  assign bus.data_valid = valid_q;
`ifdef BIT_DESHIFT_PARITY_EN
  assign bus.parity_err = perr_q;
`endif

endmodule

// File: tb/tb_bit_deshift.sv
// tb/tb_bit_deshift.sv - scoreboard bench for bit_deshift in four configurations (follows BIT_DESHIFT_PARITY_EN)
module tb_bit_deshift;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;
  int   cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // NB=1 pair shares one beat stream, NB=4 pair shares another
  logic       din1, val1, sof1, rdy1;
  logic [3:0] din4;
  logic       val4, sof4, rdy4;

  bit_deshift_if #(.NB(1), .DW(8)) if_r1 ();
  bit_deshift_if #(.NB(1), .DW(8)) if_l1 ();
  bit_deshift_if #(.NB(4), .DW(8)) if_r4 ();
  bit_deshift_if #(.NB(4), .DW(8)) if_l4 ();

  assign if_r1.din = din1;  assign if_r1.din_valid = val1;  assign if_r1.din_sof = sof1;  assign if_r1.data_ready = rdy1;
  assign if_l1.din = din1;  assign if_l1.din_valid = val1;  assign if_l1.din_sof = sof1;  assign if_l1.data_ready = rdy1;
  assign if_r4.din = din4;  assign if_r4.din_valid = val4;  assign if_r4.din_sof = sof4;  assign if_r4.data_ready = rdy4;
  assign if_l4.din = din4;  assign if_l4.din_valid = val4;  assign if_l4.din_sof = sof4;  assign if_l4.data_ready = rdy4;

  bit_deshift #(.DATA_WIDTH(8), .SHIFT_DIRECTION(1), .NUMBER_BITS(1)) u_r1 (.clk(clk), .rst_n(rst_n), .bus(if_r1.slave));
  bit_deshift #(.DATA_WIDTH(8), .SHIFT_DIRECTION(0), .NUMBER_BITS(1)) u_l1 (.clk(clk), .rst_n(rst_n), .bus(if_l1.slave));
  bit_deshift #(.DATA_WIDTH(8), .SHIFT_DIRECTION(1), .NUMBER_BITS(4)) u_r4 (.clk(clk), .rst_n(rst_n), .bus(if_r4.slave));
  bit_deshift #(.DATA_WIDTH(8), .SHIFT_DIRECTION(0), .NUMBER_BITS(4)) u_l4 (.clk(clk), .rst_n(rst_n), .bus(if_l4.slave));

  logic pe [4];
`ifdef BIT_DESHIFT_PARITY_EN
  assign pe[0] = if_r1.parity_err;
  assign pe[1] = if_l1.parity_err;
  assign pe[2] = if_r4.parity_err;
  assign pe[3] = if_l4.parity_err;
`else
  assign pe[0] = 1'b0;
  assign pe[1] = 1'b0;
  assign pe[2] = 1'b0;
  assign pe[3] = 1'b0;
`endif

  typedef struct {
    logic [7:0] data;
    logic       perr;
    int         cyc;
  } exp_t;

  exp_t  sbq [4][$];
  string nm [4] = '{"r1", "l1", "r4", "l4"};
  int    n_vec = 0;
  int    n_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
    end
  endtask

  task automatic mon(input int idx, input logic [7:0] d, input logic p);
    exp_t e;
    if (sbq[idx].size() == 0) begin
      n_vec++;
      n_err++;
      $display("FAIL %s unexpected word: got 0x%02h at cycle %0d, required no word", nm[idx], d, cyc);
    end else begin
      e = sbq[idx].pop_front();
      chk({nm[idx], " data"}, d, e.data);
`ifdef BIT_DESHIFT_PARITY_EN
      chk({nm[idx], " parity_err"}, p, e.perr);
`else
      if (p !== 1'b0) chk({nm[idx], " parity_err"}, p, 1'b0);
`endif
      if (e.cyc >= 0) chk({nm[idx], " output cycle"}, cyc, e.cyc);
    end
  endtask

  // monitor: every consumed word is popped from its scoreboard and compared
  always @(negedge clk) begin
    if (rst_n) begin
      if (if_r1.data_valid && rdy1) mon(0, if_r1.data_out, pe[0]);
      if (if_l1.data_valid && rdy1) mon(1, if_l1.data_out, pe[1]);
      if (if_r4.data_valid && rdy4) mon(2, if_r4.data_out, pe[2]);
      if (if_l4.data_valid && rdy4) mon(3, if_l4.data_out, pe[3]);
    end
  end

  task automatic sync();
    @(posedge clk);
    #1;
  endtask

  task automatic beat1(input logic b, input logic s);
    din1 = b; val1 = 1'b1; sof1 = s;
    sync();
    val1 = 1'b0; sof1 = 1'b0;
  endtask

  task automatic beat4(input logic [3:0] b, input logic s);
    din4 = b; val4 = 1'b1; sof4 = s;
    sync();
    val4 = 1'b0; sof4 = 1'b0;
  endtask

  task automatic push(input int idx, input logic [7:0] d, input logic p, input int c);
    exp_t e;
    e.data = d; e.perr = p; e.cyc = c;
    sbq[idx].push_back(e);
  endtask

  // beats[7] goes first on the wire; par < 0 sends the correct even parity
  task automatic word1(input logic [7:0] beats, input logic sof_first, input logic [7:0] er,
                       input logic [7:0] el, input int par, input logic epe, input bit timed);
    int c;
    logic pb;
    c = -1;
    for (int i = 0; i < 8; i++) begin
      if (i == 7) c = cyc + 1;
      beat1(beats[7-i], (i == 0) && sof_first);
    end
`ifdef BIT_DESHIFT_PARITY_EN
    pb = (par < 0) ? ^beats : par[0];
    c  = cyc + 1;
    beat1(pb, 1'b0);
`else
    pb = 1'b0;
`endif
    if (!timed) c = -1;
    push(0, er, epe, c);
    push(1, el, epe, c);
  endtask

  task automatic word4(input logic [3:0] b0, input logic [3:0] b1, input logic [7:0] er,
                       input logic [7:0] el, input bit timed);
    int c;
    beat4(b0, 1'b0);
    c = cyc + 1;
    beat4(b1, 1'b0);
`ifdef BIT_DESHIFT_PARITY_EN
    c = cyc + 1;
    beat4({3'b000, ^{b0, b1}}, 1'b0);
`endif
    if (!timed) c = -1;
    push(2, er, 1'b0, c);
    push(3, el, 1'b0, c);
  endtask

  initial begin
    din1 = 1'b0; val1 = 1'b0; sof1 = 1'b0; rdy1 = 1'b1;
    din4 = 4'h0; val4 = 1'b0; sof4 = 1'b0; rdy4 = 1'b1;
    rst_n = 1'b0;
    repeat (3) sync();
    rst_n = 1'b1;
    @(negedge clk);
    chk("r1 reset din_ready",  if_r1.din_ready,  1);
    chk("r1 reset data_valid", if_r1.data_valid, 0);
    chk("r1 reset data_out",   if_r1.data_out,   0);
    chk("l4 reset din_ready",  if_l4.din_ready,  1);
    chk("l4 reset data_valid", if_l4.data_valid, 0);
    chk("l4 reset data_out",   if_l4.data_out,   0);
    sync();

    // single-bit words, two back to back with no bubble
    word1(8'b1011_0010, 1'b0, 8'h4D, 8'hB2, -1, 1'b0, 1'b1);
    word1(8'b1111_0000, 1'b0, 8'h0F, 8'hF0, -1, 1'b0, 1'b1);
    repeat (3) sync();

    // nibble words
    word4(4'hA, 4'h5, 8'h5A, 8'hA5, 1'b1);
    word4(4'h3, 4'hC, 8'hC3, 8'h3C, 1'b1);
    repeat (3) sync();

    // backpressure: second word must park in HOLD
    rdy4 = 1'b0;
    word4(4'h1, 4'h1, 8'h11, 8'h11, 1'b0);
    word4(4'h2, 4'h2, 8'h22, 8'h22, 1'b0);
    @(negedge clk);
    chk("l4 hold din_ready", if_l4.din_ready, 0);
    chk("r4 hold din_ready", if_r4.din_ready, 0);
    for (int k = 0; k < 3; k++) begin
      chk("l4 stalled data_out",   if_l4.data_out,   8'h11);
      chk("l4 stalled data_valid", if_l4.data_valid, 1);
      @(negedge clk);
    end
    sync();
    rdy4 = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("l4 released din_ready", if_l4.din_ready, 1);
    chk("l4 released data_out",  if_l4.data_out,  8'h22);
    chk("r4 released din_ready", if_r4.din_ready, 1);
    repeat (3) sync();

    // resync: three stray beats, then start-of-word
    beat1(1'b1, 1'b0);
    beat1(1'b1, 1'b0);
    beat1(1'b1, 1'b0);
    word1(8'b0111_1111, 1'b1, 8'hFE, 8'h7F, -1, 1'b0, 1'b1);
    repeat (3) sync();

    // reset in the middle of a word
    for (int k = 0; k < 5; k++) beat1(1'b1, 1'b0);
    rst_n = 1'b0;
    sync();
    rst_n = 1'b1;
`ifdef BIT_DESHIFT_PARITY_EN
    word1(8'hFF, 1'b0, 8'hFF, 8'hFF, 1, 1'b1, 1'b1);
    word1(8'hFF, 1'b0, 8'hFF, 8'hFF, 0, 1'b0, 1'b1);
`else
    word1(8'hFF, 1'b0, 8'hFF, 8'hFF, -1, 1'b0, 1'b1);
`endif
    repeat (4) sync();

    for (int i = 0; i < 4; i++) chk({nm[i], " words still expected"}, sbq[i].size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/bit_deshift.md
Name: bit_deshift

Overview:
- Serial-to-parallel shift-in register; the receive-side counterpart of the bit shifter.
- Accepts NUMBER_BITS-wide beats over a valid/ready stream and shifts them into a DATA_WIDTH register.
- Presents each completed word on a registered valid/ready output.
- Sits between a serial link front-end and word-wide datapath logic.

Parameters:
- DATA_WIDTH, 8: output word width; must be an integer multiple of NUMBER_BITS.
- SHIFT_DIRECTION, 1: 1 = shift right, first beat lands in the LSBs (LSB-first link); 0 = shift left, first beat lands in the MSBs (MSB-first link).
- NUMBER_BITS, 1: bits per input beat. BEATS = DATA_WIDTH/NUMBER_BITS.

Ports:
- clk  input  1  sole clock, all logic on rising edge.
- rst_n  input  1  synchronous, active-low reset.
- din  input  NUMBER_BITS  input beat.
- din_valid  input  1  din is valid this cycle.
- din_sof  input  1  start-of-word; sampled only on an accepted beat.
- din_ready  output  1  block can accept a beat.
- data_out  output  DATA_WIDTH  assembled word.
- data_valid  output  1  data_out holds an unconsumed word.
- data_ready  input  1  consumer accepts data_out.

Behaviour:
- Clocking and reset: single clock; reset is synchronous, active-low on rst_n.
- Reset values: data_out=0, data_valid=0, shift register=0, beat count=0, state=FILL, so din_ready=1 the cycle after reset deasserts.
- An input beat is accepted when din_valid && din_ready. An output word is consumed when data_valid && data_ready.
- Shift rule, right (SHIFT_DIRECTION=1): sreg <= {din, sreg[DW-1:NB]}.
- Shift rule, left (SHIFT_DIRECTION=0): sreg <= {sreg[DW-NB-1:0], din}.
- Beat counter: width clog2(BEATS)+1; counts accepted beats 0..BEATS-1.
- State FILL: din_ready=1.
  - An accepted beat with count<BEATS-1 shifts and increments the count.
  - An accepted beat with count==BEATS-1 completes the word.
- Word completion:
  - If the output slot is free (data_valid=0, or a consume happens this cycle): next cycle data_out=completed word (including the final beat), data_valid=1, count=0, stay in FILL.
  - Otherwise: register the completed word in sreg and go to HOLD.
- Latency: data_valid rises exactly 1 cycle after the final beat is accepted.
- Throughput: a back-to-back word needs no bubble when data_ready=1.
- State HOLD: din_ready=0; sreg holds a complete word.
  - When the output slot becomes free (data_valid=0, or a consume this cycle), load data_out from sreg next cycle, set data_valid=1, count=0, and return to FILL.
  - din_ready reasserts in that same next cycle.
- Output stability: data_out and data_valid stay stable while data_valid=1 and data_ready=0.
  - A consume with no new word pending clears data_valid next cycle.
- din_sof on an accepted beat: discard any partial word.
  - That beat becomes beat 0 of a new word: sreg is reset to 0 then shifted once, count=1.
  - With BEATS==1 the word completes immediately.
  - Never affects data_out/data_valid. Ignored when din_valid=0 or in HOLD.
- Reset mid-word or in HOLD: partial word and held word are dropped, all outputs return to reset values. No partial word is ever emitted.
- Simultaneous final beat and consume of the previous word: both happen; data_valid stays 1 and data_out updates to the new word.

Optional Feature:
- Macro: BIT_DESHIFT_PARITY_EN.
- Defined:
  - Each word is BEATS+1 beats long; the extra trailing beat carries a parity bit in din[0] (even parity over the DATA_WIDTH data bits); other bits of that beat are ignored and the beat is not shifted into data.
  - Adds output parity_err (1 bit), registered alongside data_out and valid while data_valid=1; it is 1 when the XOR of the data bits and the parity bit is 1. Reset value 0.
  - din_sof on the parity beat restarts as a data beat 0.
- Not defined: no parity beat and no parity_err port; the word is exactly BEATS beats.

Test Plan:
- DW=8, NB=1, dir=1, data_ready=1; beats 1,0,1,1,0,0,1,0 in consecutive cycles -> data_out=0x4D with data_valid high for exactly 1 cycle, 1 cycle after beat 8.
- Same beats with dir=0 -> 0xB2.
- DW=8, NB=4 -> dir=0: beats 0xA,0x5 give 0xA5; dir=1 gives 0x5A.
- Backpressure: data_ready=0; send word 0x11 then word 0x22 continuously (NB=4, dir=0).
  - Expected: 0x11 held stable; din_ready drops after the last beat of 0x22.
  - Raise data_ready: 0x11 consumed, 0x22 appears next cycle, din_ready returns.
- Resync: 3 beats of 1, then a beat of 0 with din_sof=1, then 7 beats of 1 (DW=8, NB=1, dir=1) -> single word 0xFE, nothing earlier.
- Reset mid-word (after 5 beats, rst_n=0 for 1 cycle), then 8 beats of 1 -> data_out=0xFF, data_valid never pulses before it. With BIT_DESHIFT_PARITY_EN: 0xFF plus parity 1 -> parity_err=1; plus parity 0 -> parity_err=0.
